frame_scheduler: RTL

Per-frame sequencer for the game-logic datapath. On each frame tick it issues the calculation_time strobe to input control, then runs the doodle-physics step, a collision sweep over all platforms through one shared collision checker, and the scroll step, one after another. It sits between the VGA timing generator (frame tick) and the physics, collision and scroll units, and reports frame completion and overrun.

---
 rtl/frame_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// Per-frame game-logic sequencer: calc strobe, physics, collision sweep, scroll.
// Optional watchdog on pending requests enabled by defining WATCHDOG_EN.
module frame_scheduler #(
  parameter int NUM_PLATFORMS  = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [1:0]                       game_state,
  output logic                             calc_time,
  output logic                             phys_req,
  input  logic                             phys_ack,
  output logic                             coll_req,
  output logic [$clog2(NUM_PLATFORMS)-1:0] coll_idx,
  input  logic                             coll_ack,
  input  logic                             coll_hit,
  output logic                             scroll_req,
  input  logic                             scroll_ack,
  output logic                             hit_valid,
  output logic [$clog2(NUM_PLATFORMS)-1:0] hit_idx,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun,
  output logic                             timeout_err
);

  localparam int IDX_W = $clog2(NUM_PLATFORMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLATFORMS - 1);

  if (NUM_PLATFORMS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("frame_scheduler: NUM_PLATFORMS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, CALC, PHYS, COLL, SCROLL, DONE} state_t;

  state_t state, state_nx;
  logic   wd_expire;

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            waiting;

  assign waiting   = (phys_req & ~phys_ack) | (coll_req & ~coll_ack) | (scroll_req & ~scroll_ack);
  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a transfer.
  assign wd_expire = waiting && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !waiting) wd_cnt <= '0;
    else                 wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)            timeout_err <= 1'b0;
    else if (wd_expire) timeout_err <= 1'b1;
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = CALC;
      CALC:    state_nx = (game_state == 2'd1) ? PHYS : DONE;
      PHYS: begin
        if (phys_ack)       state_nx = COLL;
        else if (wd_expire) state_nx = DONE;
      end
      COLL: begin
        if (coll_ack) begin
          if (coll_idx == LAST_IDX) state_nx = SCROLL;
        end else if (wd_expire) begin
          state_nx = DONE;
        end
      end
      SCROLL:  if (scroll_ack || wd_expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    calc_time  = 1'b0;
    phys_req   = 1'b0;
    coll_req   = 1'b0;
    scroll_req = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE:    busy       = 1'b0;
      CALC:    calc_time  = 1'b1;
      PHYS:    phys_req   = 1'b1;
      COLL:    coll_req   = 1'b1;
      SCROLL:  scroll_req = 1'b1;
      DONE:    frame_done = 1'b1;
      default: busy       = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state == CALC)
      coll_idx <= '0;
    else if (state == COLL && coll_ack && coll_idx != LAST_IDX)
      coll_idx <= coll_idx + 1'b1;
  end

  // Only the first hit of the sweep is kept, i.e. the lowest platform index.
  always_ff @(posedge clk) begin
    if (rst || state == CALC) begin
      hit_valid <= 1'b0;
      hit_idx   <= '0;
    end else if (state == COLL && coll_ack && coll_hit && !hit_valid) begin
      hit_valid <= 1'b1;
      hit_idx   <= coll_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               overrun <= 1'b0;
    else if (frame_start && state != IDLE) overrun <= 1'b1;
  end

endmodule
